uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receiver: the downstream stage of uart_tx. It recovers 8N1 frames from the serial line and presents each byte on a valid/ready handshake.
// - Typical use: rxd is driven by an external pin or by the txd output of uart_tx.
// - Data is LSB first. There is one start bit (0) and one stop bit (1). Each bit is sampled at its mid-point.
// PARAMETERS
// - clk_hz     50_000_000  system clock frequency in Hz
// - baud_rate  115_200     serial bit rate
// - Derived: clks_per_bit = clk_hz/baud_rate (integer divide); half_bit = clks_per_bit/2.
// - Timer width = $clog2(clks_per_bit), with a minimum of 1 bit.
// - clks_per_bit must be >= 4. Enforce this with an elaboration-time check.
// PORTS
// - clk        in   1  system clock, rising edge
// - rst_n      in   1  asynchronous reset, active low
// - rxd        in   1  serial input, asynchronous to clk, idles high
// - rx_ready   in   1  consumer can accept rx_data this cycle
// - rx_valid   out  1  rx_data holds an unread byte
// - rx_data    out  8  received byte
// - frame_err  out  1  1-cycle pulse: stop bit was sampled as 0
// - overrun    out  1  1-cycle pulse: a good byte was dropped because the holding register was full
// BEHAVIOUR
// - Reset (rst_n=0, async) forces:
//   - outputs: rx_valid=0, rx_data=0, frame_err=0, overrun=0
//   - internal: state=IDLE, synchroniser flops=1, bit timer=0, bit index=0, shift register=0
// - Reset mid-frame aborts the frame. No byte and no error is reported.
// - Synchroniser: rxd passes through 2 flops to give rxd_s. Only rxd_s is used internally.
// - IDLE: bit timer=0. When rxd_s==0, go to START.
// - START:
//   - Timer counts up each cycle.
//   - At timer==half_bit-1: if rxd_s==0, clear timer and bit index and go to DATA.
//   - If rxd_s==1 at that point, treat it as a glitch and return to IDLE with no output.
// - DATA:
//   - At timer==clks_per_bit-1: shift[index] <= rxd_s and clear timer.
//   - If index==7, go to STOP. Otherwise index++.
//   - This sampling lands each data bit at its mid-point.
// - STOP: at timer==clks_per_bit-1, sample rxd_s and clear timer.
//   - rxd_s==1 (good frame), next cycle:
//     - If rx_valid==0, or rx_valid & rx_ready in the same cycle: rx_data<=shift, rx_valid<=1.
//     - Otherwise keep the old rx_data and pulse overrun for 1 cycle.
//     - Go to IDLE.
//   - rxd_s==0: pulse frame_err for 1 cycle, deliver no byte, go to BREAK.
// - BREAK: wait for rxd_s==1, then go to IDLE. A held-low line never re-triggers a start.
// - Handshake:
//   - rx_valid stays high until a rising edge with rx_ready=1, which clears it.
//   - rx_data is stable while rx_valid=1.
//   - rx_ready is ignored while rx_valid=0.
// - Simultaneous events:
//   - Consumer accepts and a new byte completes in the same cycle: the new byte is loaded, rx_valid stays 1, no overrun.
//   - frame_err and overrun are never asserted together.
// - Latency: the last rx_valid rise is ~2 + 9.5*clks_per_bit + 1 cycles after the rxd start-bit falling edge (±1).
// - Receiving continues regardless of rx_valid. Back-to-back frames with a 1-bit stop are received without loss.
// TESTING
// - Common settings: clk_hz=1_000_000, baud_rate=100_000 (10 clks/bit). Drive rxd from a uart_tx instance with the same parameters, or from a bench task.
// - Loopback: uart_tx sends 0xA5 with rx_ready=1 -> one rx_valid cycle, rx_data=0xA5, no frame_err or overrun.
// - Glitch: rxd low for 3 cycles, then high -> state returns to IDLE, no rx_valid, no frame_err.
// - Framing: frame 0x3C with the stop bit forced to 0, then rxd high -> frame_err pulses once, rx_valid stays 0, next frame 0x55 is received correctly.
// - Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun pulses once. Raise rx_ready -> rx_valid drops and rx_data remains 0x11.
// - Back-to-back: 0x00, 0xFF, 0x81 with no idle gap, rx_ready=1 -> three rx_valid pulses with those values in order.
// - Reset: assert rst_n=0 during DATA bit 4 of 0xF0, release, then send 0x96 -> only 0x96 is delivered, and all outputs were 0 during reset.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding register on a valid/ready handshake.
// The start bit is qualified at its mid-point. Every later bit is sampled one full bit
// period after the previous sample, so each sample lands mid-bit.
module uart_rx #(
  parameter int unsigned clk_hz    = 50_000_000,
  parameter int unsigned baud_rate = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned ClksPerBit = clk_hz / baud_rate;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned TimerW     = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

  localparam logic [TimerW-1:0] TimerLast = TimerW'(ClksPerBit - 1);
  localparam logic [TimerW-1:0] TimerHalf = TimerW'(HalfBit - 1);

  // Fewer than 4 clocks per bit leaves no room for a meaningful mid-bit sample.
  if (ClksPerBit < 4) begin : gen_cpb_check
    $error("uart_rx: clk_hz/baud_rate must be at least 4");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              rxd_s;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  assign rxd_s = sync_q[1];

  // Two-flop synchroniser; it resets to the idle line level so reset cannot fake a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic for the frame FSM, holding register and error pulses.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    // A consumer handshake frees the holding register; a completing byte may refill it below.
    rx_valid_d  = rx_valid_q & ~rx_ready;
    rx_data_d   = rx_data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (!rxd_s) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (timer_q == TimerHalf) begin
          timer_d = '0;
          idx_d   = '0;
          // A line that is high again at mid start bit was a glitch.
          state_d = rxd_s ? StIdle : StData;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StData: begin
        if (timer_q == TimerLast) begin
          timer_d         = '0;
          shift_d[idx_q]  = rxd_s;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StStop: begin
        if (timer_q == TimerLast) begin
          timer_d = '0;
          if (rxd_s) begin
            state_d = StIdle;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StBreak: begin
        // A line held low must return high before a new start bit is accepted.
        timer_d = '0;
        if (rxd_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: a table of single frames plus
// hand-written glitch, overrun, back-to-back, latency and mid-frame reset sequences.
module tb_uart_rx;

  localparam int unsigned Cpb = 10;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       rx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  // Monitor state, written only by the monitor process.
  int         cyc       = 0;
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         both_cnt  = 0;
  int         rise_cyc  = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] acc_q[$];

  int start_cyc = 0;

  uart_rx #(
    .clk_hz   (1_000_000),
    .baud_rate(100_000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rx_ready (rx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted bytes, error pulses and the cycle of each rx_valid rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (rx_valid && !valid_prev) rise_cyc = cyc;
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (overrun) ovr_cnt = ovr_cnt + 1;
      if (frame_err && overrun) both_cnt = both_cnt + 1;
    end
    valid_prev = rx_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    rxd = 1'b0;
    idle(Cpb);
    for (int b = 0; b < 8; b++) begin
      rxd = d[b];
      idle(Cpb);
    end
    rxd = stop;
    idle(Cpb);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_acc;
    int         exp_ferr;
  } vec_t;

  localparam int NumVec = 7;
  vec_t vecs[NumVec];

  initial begin
    int base_acc;
    int base_ferr;
    int base_ovr;
    int lat;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_acc: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_acc: 0, exp_ferr: 1};
    vecs[2] = '{data: 8'h55, stop: 1'b1, exp_acc: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'h01, stop: 1'b1, exp_acc: 1, exp_ferr: 0};
    vecs[4] = '{data: 8'h80, stop: 1'b1, exp_acc: 1, exp_ferr: 0};
    vecs[5] = '{data: 8'hC3, stop: 1'b0, exp_acc: 0, exp_ferr: 1};
    vecs[6] = '{data: 8'h6E, stop: 1'b1, exp_acc: 1, exp_ferr: 0};

    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    idle(3);
    chk("reset_valid", int'(rx_valid), 0);
    chk("reset_data", int'(rx_data), 0);
    chk("reset_ferr", int'(frame_err), 0);
    chk("reset_ovr", int'(overrun), 0);
    rst_n = 1'b1;
    idle(5);

    // Single-frame table; a bad stop bit is followed by an idle-high line.
    for (int i = 0; i < NumVec; i++) begin
      base_acc  = acc_q.size();
      base_ferr = ferr_cnt;
      base_ovr  = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      idle(2 * Cpb);
      chk($sformatf("vec%0d_count", i), acc_q.size() - base_acc, vecs[i].exp_acc);
      if (vecs[i].exp_acc == 1 && acc_q.size() > base_acc)
        chk($sformatf("vec%0d_data", i), int'(acc_q[base_acc]), int'(vecs[i].data));
      chk($sformatf("vec%0d_ferr", i), ferr_cnt - base_ferr, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_ovr", i), ovr_cnt - base_ovr, 0);
      chk($sformatf("vec%0d_valid_idle", i), int'(rx_valid), 0);
    end

    // Glitch: 3 low cycles never survive to the mid start-bit check.
    base_acc  = acc_q.size();
    base_ferr = ferr_cnt;
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(3 * Cpb);
    chk("glitch_count", acc_q.size() - base_acc, 0);
    chk("glitch_valid", int'(rx_valid), 0);
    chk("glitch_ferr", ferr_cnt - base_ferr, 0);
    // Receiver must still be usable after the glitch.
    send_frame(8'h5A, 1'b1);
    idle(2 * Cpb);
    chk("post_glitch_count", acc_q.size() - base_acc, 1);
    if (acc_q.size() > base_acc) chk("post_glitch_data", int'(acc_q[base_acc]), 8'h5A);

    // Latency from start-bit edge to rx_valid rise.
    send_frame(8'hE7, 1'b1);
    idle(2 * Cpb);
    lat = rise_cyc - start_cyc;
    checks = checks + 1;
    if (lat < 97 || lat > 99) begin
      failures = failures + 1;
      $display("FAIL latency: got %0d expected 97..99", lat);
    end

    // Overrun: second good byte dropped while the first is unread.
    rx_ready  = 1'b0;
    base_acc  = acc_q.size();
    base_ovr  = ovr_cnt;
    base_ferr = ferr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2 * Cpb);
    chk("ovr_valid", int'(rx_valid), 1);
    chk("ovr_data", int'(rx_data), 8'h11);
    chk("ovr_pulses", ovr_cnt - base_ovr, 1);
    chk("ovr_ferr", ferr_cnt - base_ferr, 0);
    chk("ovr_no_accept", acc_q.size() - base_acc, 0);
    rx_ready = 1'b1;
    idle(1);
    chk("ovr_valid_drop", int'(rx_valid), 0);
    chk("ovr_data_hold", int'(rx_data), 8'h11);
    chk("ovr_accept_count", acc_q.size() - base_acc, 1);

    // Back-to-back frames with a single stop bit.
    base_acc = acc_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(2 * Cpb);
    chk("b2b_count", acc_q.size() - base_acc, 3);
    if (acc_q.size() >= base_acc + 3) begin
      chk("b2b_0", int'(acc_q[base_acc]), 8'h00);
      chk("b2b_1", int'(acc_q[base_acc+1]), 8'hFF);
      chk("b2b_2", int'(acc_q[base_acc+2]), 8'h81);
    end

    // Mid-frame reset with a held byte pending.
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(2 * Cpb);
    chk("pre_reset_valid", int'(rx_valid), 1);
    chk("pre_reset_data", int'(rx_data), 8'h5A);
    rxd = 1'b0;
    idle(Cpb);
    for (int b = 0; b < 4; b++) begin
      rxd = 1'b0;  // low nibble of 0xF0
      idle(Cpb);
    end
    rxd = 1'b1;
    idle(Cpb / 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", int'(rx_valid), 0);
    chk("mid_reset_data", int'(rx_data), 0);
    chk("mid_reset_ferr", int'(frame_err), 0);
    chk("mid_reset_ovr", int'(overrun), 0);
    idle(3);
    rst_n    = 1'b1;
    rx_ready = 1'b1;
    base_acc  = acc_q.size();
    base_ferr = ferr_cnt;
    base_ovr  = ovr_cnt;
    idle(3 * Cpb);
    send_frame(8'h96, 1'b1);
    idle(2 * Cpb);
    chk("post_reset_count", acc_q.size() - base_acc, 1);
    if (acc_q.size() > base_acc) chk("post_reset_data", int'(acc_q[base_acc]), 8'h96);
    chk("post_reset_ferr", ferr_cnt - base_ferr, 0);
    chk("post_reset_ovr", ovr_cnt - base_ovr, 0);

    chk("ferr_ovr_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
